// File: rtl/fir_seq_ctrl_if.sv
// fir_seq_ctrl_if: bundles everything between the FIR pass sequencer and its
// surroundings (control/status, dual-port sample memory, FIR core stream).
//   control : start, input_addr, output_addr, sample_count -> busy, done, err, cycle_count
//   memory  : port A registered read (mem_addr_a / mem_data_out_a),
//             port B write (mem_we_b / mem_addr_b / mem_data_in_b)
//   core    : sample out (core_in_valid/data, core_in_ready),
//             result in  (core_out_valid/data, no backpressure)
// The sequencer uses the master modport; the environment uses slave.
interface fir_seq_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 32
);
  logic              start;
  logic [ADDR_W-1:0] input_addr;
  logic [ADDR_W-1:0] output_addr;
  logic [ADDR_W-1:0] sample_count;
  logic [ADDR_W-1:0] mem_addr_a;
  logic [DATA_W-1:0] mem_data_out_a;
  logic              mem_we_b;
  logic [ADDR_W-1:0] mem_addr_b;
  logic [DATA_W-1:0] mem_data_in_b;
  logic              core_in_valid;
  logic [DATA_W-1:0] core_in_data;
  logic              core_in_ready;
  logic              core_out_valid;
  logic [DATA_W-1:0] core_out_data;
  logic              busy;
  logic              done;
  logic              err;
  logic [CNT_W-1:0]  cycle_count;

  modport master (
    input  start, input_addr, output_addr, sample_count,
    input  mem_data_out_a, core_in_ready, core_out_valid, core_out_data,
    output mem_addr_a, mem_we_b, mem_addr_b, mem_data_in_b,
    output core_in_valid, core_in_data, busy, done, err, cycle_count
  );

  modport slave (
    output start, input_addr, output_addr, sample_count,
    output mem_data_out_a, core_in_ready, core_out_valid, core_out_data,
    input  mem_addr_a, mem_we_b, mem_addr_b, mem_data_in_b,
    input  core_in_valid, core_in_data, busy, done, err, cycle_count
  );
endinterface

// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: runs one FIR pass. Streams sample_count samples from the
// sample memory (port A) through a 2-entry skid FIFO into the FIR core,
// writes each core result back to the output region (port B), and counts
// the cycles the pass takes.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-low reset
//   bus  - fir_seq_ctrl_if.master (control/status, memory, core stream)
module fir_seq_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input logic           clk,
  input logic           rst,
  fir_seq_ctrl_if.master bus
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] in_base_q, in_base_d;
  logic [ADDR_W-1:0] out_base_q, out_base_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;    // reads issued
  logic [ADDR_W-1:0] sent_q, sent_d;        // samples handed to the core
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;    // results written back
  logic              infl_q, infl_d;        // read issued last cycle, data on port A now
  logic [DATA_W-1:0] fifo_q [2];
  logic [DATA_W-1:0] fifo_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        occ_q, occ_d;
  logic [IDLE_W-1:0] idle_q, idle_d;        // consecutive DRAIN cycles without a result
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;
  logic [DATA_W-1:0] data_b_q, data_b_d;

  logic              pop;
  logic              issue;
  logic              wr_fire;
  logic [1:0]        slots_used;
  logic [CNT_W-1:0]  cycle_inc;

  assign pop = (occ_q != 2'd0) && bus.core_in_ready;

  // Occupancy is taken after this cycle's pop so that a steady stream with
  // ready=1 can issue a new read every cycle while never exceeding two
  // samples between the memory and the core.
  assign slots_used = occ_q + {1'b0, infl_q} - {1'b0, pop};
  assign issue      = (state_q == S_RUN) && (rd_cnt_q < count_q) && (slots_used < 2'd2);

  assign wr_fire = ((state_q == S_RUN) || (state_q == S_DRAIN)) &&
                   bus.core_out_valid && (wr_cnt_q < count_q);

  assign cycle_inc = (cycle_q == '1) ? cycle_q : cycle_q + CNT_W'(1);

  always_comb begin
    // NOTE: every _d takes its _q value first, so no branch can infer a latch.
    state_d    = state_q;
    in_base_d  = in_base_q;
    out_base_d = out_base_q;
    count_d    = count_q;
    rd_cnt_d   = rd_cnt_q;
    sent_d     = sent_q;
    wr_cnt_d   = wr_cnt_q;
    infl_d     = issue;
    fifo_d     = fifo_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    occ_d      = occ_q + {1'b0, infl_q} - {1'b0, pop};
    idle_d     = idle_q;
    cycle_d    = cycle_q;
    err_d      = err_q;
    we_d       = 1'b0;
    addr_b_d   = addr_b_q;
    data_b_d   = data_b_q;

    if (issue) rd_cnt_d = rd_cnt_q + ADDR_W'(1);

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      sent_d   = sent_q + ADDR_W'(1);
    end

    if (infl_q) begin
      fifo_d[wr_ptr_q] = bus.mem_data_out_a;
      wr_ptr_d         = ~wr_ptr_q;
    end

    if (wr_fire) begin
      we_d     = 1'b1;
      addr_b_d = out_base_q + wr_cnt_q;
      data_b_d = bus.core_out_data;
      wr_cnt_d = wr_cnt_q + ADDR_W'(1);
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          in_base_d  = bus.input_addr;
          out_base_d = bus.output_addr;
          count_d    = bus.sample_count;
          rd_cnt_d   = '0;
          sent_d     = '0;
          wr_cnt_d   = '0;
          infl_d     = 1'b0;
          rd_ptr_d   = 1'b0;
          wr_ptr_d   = 1'b0;
          occ_d      = 2'd0;
          idle_d     = '0;
          err_d      = 1'b0;
          // The cycle after acceptance is the first counted cycle.
          cycle_d    = CNT_W'(1);
          state_d    = (bus.sample_count == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        cycle_d = cycle_inc;
        idle_d  = '0;
        if (sent_q == count_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        cycle_d = cycle_inc;
        idle_d  = bus.core_out_valid ? '0 : idle_q + IDLE_W'(1);
        if (wr_cnt_q == count_q) begin
          state_d = S_DONE;
        end else if (!bus.core_out_valid && (idle_q == IDLE_W'(TIMEOUT - 1))) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      in_base_q  <= '0;
      out_base_q <= '0;
      count_q    <= '0;
      rd_cnt_q   <= '0;
      sent_q     <= '0;
      wr_cnt_q   <= '0;
      infl_q     <= 1'b0;
      // NOTE: the two skid entries are reset because the head drives
      // core_in_data, which must read 0 out of reset; larger storage would not be.
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      idle_q     <= '0;
      cycle_q    <= '0;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_b_q   <= '0;
      data_b_q   <= '0;
    end else begin
      state_q    <= state_d;
      in_base_q  <= in_base_d;
      out_base_q <= out_base_d;
      count_q    <= count_d;
      rd_cnt_q   <= rd_cnt_d;
      sent_q     <= sent_d;
      wr_cnt_q   <= wr_cnt_d;
      infl_q     <= infl_d;
      fifo_q     <= fifo_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      idle_q     <= idle_d;
      cycle_q    <= cycle_d;
      err_q      <= err_d;
      we_q       <= we_d;
      addr_b_q   <= addr_b_d;
      data_b_q   <= data_b_d;
    end
  end

  // Port A address is the next read; it is only consumed by the memory
  // when issue is high, otherwise it is simply a don't-care read.
  assign bus.mem_addr_a    = in_base_q + rd_cnt_q;
  assign bus.mem_we_b      = we_q;
  assign bus.mem_addr_b    = addr_b_q;
  assign bus.mem_data_in_b = data_b_q;
  assign bus.core_in_valid = (occ_q != 2'd0);
  assign bus.core_in_data  = fifo_q[rd_ptr_q];
  assign bus.busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.done          = (state_q == S_DONE);
  assign bus.err           = err_q;
  assign bus.cycle_count   = cycle_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb_fir_seq_ctrl: directed bench for fir_seq_ctrl with a behavioural
// dual-port memory and a delay-line FIR core stub (result = sample ^ 8'h5A).
module tb_fir_seq_ctrl;

  logic clk;
  logic rst;

  fir_seq_ctrl_if #(.ADDR_W(10), .DATA_W(8), .CNT_W(32)) bus ();

  fir_seq_ctrl #(.ADDR_W(10), .DATA_W(8), .CNT_W(32), .TIMEOUT(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [7:0] init_val(input logic [9:0] a);
    return 8'(a * 7 + 3);
  endfunction

  function automatic logic [7:0] exp_out(input logic [9:0] a);
    return init_val(a) ^ 8'h5A;
  endfunction

  // ---------------- memory model ----------------
  logic [7:0] mem [1024];
  logic [7:0] mem_q = 8'd0;
  bit         mem_loaded = 1'b0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(10'(i));
      mem_loaded <= 1'b1;
    end else if (bus.mem_we_b) begin
      mem[bus.mem_addr_b] <= bus.mem_data_in_b;
    end
    mem_q <= mem[bus.mem_addr_a];
  end
  assign bus.mem_data_out_a = mem_q;

  // ---------------- core stub ----------------
  logic [2:0] lat_sel = 3'd5;   // latency - 1
  bit         rtog    = 1'b0;   // ready pattern 1,0,0,1
  bit         nores   = 1'b0;   // never produce results
  logic [1:0] rcyc    = 2'd0;
  logic       sr_v [8];
  logic [7:0] sr_d [8];

  always @(posedge clk) begin
    rcyc <= rcyc + 2'd1;
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        sr_v[i] <= 1'b0;
        sr_d[i] <= 8'd0;
      end
    end else begin
      sr_v[0] <= bus.core_in_valid && bus.core_in_ready;
      sr_d[0] <= bus.core_in_data ^ 8'h5A;
      for (int i = 1; i < 8; i++) begin
        sr_v[i] <= sr_v[i-1];
        sr_d[i] <= sr_d[i-1];
      end
    end
  end
  assign bus.core_in_ready  = !rtog || (rcyc == 2'd0) || (rcyc == 2'd3);
  assign bus.core_out_valid = !nores && sr_v[lat_sel];
  assign bus.core_out_data  = sr_d[lat_sel];

  // ---------------- monitor ----------------
  logic [17:0] wq[$];   // {addr, data} of every port-B write in the pass
  logic [7:0]  sq[$];   // samples accepted by the core in the pass
  logic [9:0]  mon_base = 10'd0;
  int          max_out  = 0;

  always @(posedge clk) begin
    if (rst && bus.start && !bus.busy) begin
      wq.delete();
      sq.delete();
      max_out  = 0;
      mon_base = bus.input_addr;
    end else if (rst) begin
      if (bus.busy) begin
        int o;
        o = int'(10'(bus.mem_addr_a - mon_base)) - sq.size();
        if (o > max_out) max_out = o;
      end
      if (bus.core_in_valid && bus.core_in_ready) sq.push_back(bus.core_in_data);
      if (bus.mem_we_b) wq.push_back({bus.mem_addr_b, bus.mem_data_in_b});
    end
  end

  // ---------------- helpers ----------------
  task automatic check_reset_outs(input string tag);
    check({tag, "_addr_a"}, bus.mem_addr_a, 0);
    check({tag, "_we_b"}, bus.mem_we_b, 0);
    check({tag, "_addr_b"}, bus.mem_addr_b, 0);
    check({tag, "_data_b"}, bus.mem_data_in_b, 0);
    check({tag, "_in_valid"}, bus.core_in_valid, 0);
    check({tag, "_in_data"}, bus.core_in_data, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_err"}, bus.err, 0);
    check({tag, "_cycles"}, bus.cycle_count, 0);
  endtask

  task automatic run_pass(input logic [9:0] ib, input logic [9:0] ob, input logic [9:0] n,
                          input logic [2:0] lsel, input bit tog, input bit nr, input bit gl,
                          output int waited);
    lat_sel = lsel;
    rtog    = tog;
    nores   = nr;
    @(posedge clk); #1;
    bus.input_addr   = ib;
    bus.output_addr  = ob;
    bus.sample_count = n;
    bus.start        = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    waited    = 1;
    while (!bus.done && waited < 3000) begin
      bus.start = gl && (waited == 8);
      @(posedge clk); #1;
      waited++;
    end
    bus.start = 1'b0;
    check("done_seen", bus.done, 1);
  endtask

  task automatic check_writes(input logic [9:0] ib, input logic [9:0] ob, input int n);
    check("wr_count", wq.size(), n);
    for (int i = 0; i < n && i < wq.size(); i++) begin
      check("wr_addr", wq[i][17:8], 10'(ob + i));
      check("wr_data", wq[i][7:0], exp_out(10'(ib + i)));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int w_slow;
    int nw;
    int k;

    rst              = 1'b0;
    bus.start        = 1'b0;
    bus.input_addr   = '0;
    bus.output_addr  = '0;
    bus.sample_count = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("rst");
    rst = 1'b1;

    // Pass 1: latency 6, ready=1, stray start mid-run. N+4+L = 30 cycles.
    run_pass(10'd0, 10'd32, 10'd20, 3'd5, 1'b0, 1'b0, 1'b1, w_slow);
    check("p1_waited", w_slow, 30);
    check("p1_cycles", bus.cycle_count, 30);
    check("p1_err", bus.err, 0);
    check("p1_busy", bus.busy, 0);
    check_writes(10'd0, 10'd32, 20);
    check("p1_first_data", wq.size() > 0 ? wq[0][7:0] : 8'd0, 8'h59);
    check("p1_last_data", wq.size() > 19 ? wq[19][7:0] : 8'd0, 8'hD2);

    // Pass 2: latency 3 -> 27 cycles, same memory contents.
    run_pass(10'd0, 10'd32, 10'd20, 3'd2, 1'b0, 1'b0, 1'b0, w);
    check("p2_cycles", bus.cycle_count, 27);
    check("p2_faster", bus.cycle_count < 32'(w_slow), 1);
    check_writes(10'd0, 10'd32, 20);
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) check("p2_mem", mem[32 + i], exp_out(10'(i)));

    // Pass 3: ready toggling 1,0,0,1.
    run_pass(10'd0, 10'd32, 10'd20, 3'd2, 1'b1, 1'b0, 1'b0, w);
    check("p3_samples", sq.size(), 20);
    for (int i = 0; i < 20 && i < sq.size(); i++) check("p3_sample", sq[i], init_val(10'(i)));
    check("p3_outstanding", max_out <= 2, 1);
    check("p3_err", bus.err, 0);
    check_writes(10'd0, 10'd32, 20);

    // Count 0: DONE the cycle after start, cycle_count 1, no write.
    run_pass(10'd5, 10'd100, 10'd0, 3'd2, 1'b0, 1'b0, 1'b0, w);
    check("c0_waited", w, 1);
    check("c0_cycles", bus.cycle_count, 1);
    repeat (3) @(posedge clk);
    #1;
    check("c0_no_write", wq.size(), 0);
    check("c0_done_held", bus.done, 1);

    // Timeout: 3 samples, core never answers. N+4+TIMEOUT = 1031.
    run_pass(10'd0, 10'd200, 10'd3, 3'd2, 1'b0, 1'b1, 1'b0, w);
    check("to_err", bus.err, 1);
    check("to_cycles", bus.cycle_count, 1031);
    check("to_no_write", wq.size(), 0);

    // Reset mid-run at sample 7; err cleared by the accepted start.
    lat_sel = 3'd5;
    rtog    = 1'b0;
    nores   = 1'b0;
    @(posedge clk); #1;
    bus.input_addr   = 10'd0;
    bus.output_addr  = 10'd32;
    bus.sample_count = 10'd20;
    bus.start        = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("mr_err_cleared", bus.err, 0);
    check("mr_busy", bus.busy, 1);
    k = 0;
    while (sq.size() < 7 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("mr_reach_s7", sq.size(), 7);
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outs("mr");
    rst = 1'b1;
    nw  = wq.size();
    repeat (15) @(posedge clk);
    #1;
    check("mr_no_write", wq.size(), nw);
    check("mr_idle", bus.busy, 0);

    // Pass after reset completes normally.
    run_pass(10'd0, 10'd32, 10'd20, 3'd2, 1'b0, 1'b0, 1'b0, w);
    check("ar_cycles", bus.cycle_count, 27);
    check_writes(10'd0, 10'd32, 20);

    // Address wrap: in 1020..1023,0,1 -> out 1022,1023,0..3. 6+4+3 = 13.
    run_pass(10'd1020, 10'd1022, 10'd6, 3'd2, 1'b0, 1'b0, 1'b0, w);
    check("wr_cycles", bus.cycle_count, 13);
    check("wr_samples", sq.size(), 6);
    for (int i = 0; i < 6 && i < sq.size(); i++) check("wr_sample", sq[i], init_val(10'(1020 + i)));
    check_writes(10'd1020, 10'd1022, 6);
    check("wr_first_data", wq.size() > 0 ? wq[0][7:0] : 8'd0, 8'hBD);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
